// File: rtl/univ_shift_reg_n.sv
// Universal WIDTH-bit shift register with parallel load, rotate,
// arithmetic shift, clock enable and a counted multi-step sequencer.
module univ_shift_reg_n #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic [2:0]         mode,
    input  logic               dr,
    input  logic               dl,
    input  logic [WIDTH-1:0]   pdata,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   q,
    output logic               sout_r,
    output logic               sout_l,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHL  = 3'b001,
        M_SHR  = 3'b010,
        M_ROL  = 3'b011,
        M_ROR  = 3'b100,
        M_ASR  = 3'b101,
        M_LOAD = 3'b110,
        M_RSVD = 3'b111
    } mode_e;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic [WIDTH-1:0]   q_q, q_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    mode_e              mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    mode_e              mode_in;
    logic               counted_mode;
    logic               last_step;

    // One step of the selected operation; serial inputs are sampled live.
    function automatic logic [WIDTH-1:0] step_fn(
        input mode_e            m,
        input logic [WIDTH-1:0] cur,
        input logic             sdl,
        input logic             sdr,
        input logic [WIDTH-1:0] pd
    );
        logic [WIDTH-1:0] r;
        r = cur;
        unique case (m)
            M_SHL:  r = {cur[WIDTH-2:0], sdl};
            M_SHR:  r = {sdr, cur[WIDTH-1:1]};
            M_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_LOAD: r = pd;
            M_HOLD: r = cur;
            M_RSVD: r = cur;
            default: r = cur;
        endcase
        return r;
    endfunction

    assign mode_in = mode_e'(mode);

    // Only the shift/rotate modes can be run as a counted sequence.
    always_comb begin
        counted_mode = 1'b0;
        unique case (mode_in)
            M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: counted_mode = 1'b1;
            default:                           counted_mode = 1'b0;
        endcase
    end

    assign last_step = (cnt_q == CNT_ONE);

    // Next-state: stall, counted step, accept, or free-running step.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!en) begin
            done_d = 1'b0;
        end else if (busy_q) begin
            q_d   = step_fn(mode_q, q_q, dl, dr, pdata);
            cnt_d = cnt_q - CNT_ONE;
            if (last_step) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start && counted_mode) begin
            mode_d = mode_in;
            if (shamt == '0) begin
                done_d = 1'b1;
            end else begin
                cnt_d  = shamt;
                busy_d = 1'b1;
            end
        end else begin
            q_d = step_fn(mode_in, q_q, dl, dr, pdata);
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            q_q    <= '0;
            cnt_q  <= '0;
            mode_q <= M_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Scoreboard bench for univ_shift_reg_n: a reference model pushes the
// expected state per edge, which is popped and compared after the edge.
module tb_univ_shift_reg_n;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          en;
    logic [2:0]    mode;
    logic          dr;
    logic          dl;
    logic [W-1:0]  pdata;
    logic          start;
    logic [SW-1:0] shamt;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0]  m_q;
    logic [SW-1:0] m_cnt;
    logic [2:0]    m_mode;
    logic          m_busy;
    logic          m_done;

    univ_shift_reg_n #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .mode   (mode),
        .dr     (dr),
        .dl     (dl),
        .pdata  (pdata),
        .start  (start),
        .shamt  (shamt),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_step(input logic [2:0] m,
                                              input logic [W-1:0] v);
        case (m)
            3'd1:    return (v << 1) | W'(dl);
            3'd2:    return (v >> 1) | (W'(dr) << (W - 1));
            3'd3:    return (v << 1) | W'(v[W-1]);
            3'd4:    return (v >> 1) | (W'(v[0]) << (W - 1));
            3'd5:    return (v >> 1) | (W'(v[W-1]) << (W - 1));
            3'd6:    return pdata;
            default: return v;
        endcase
    endfunction

    // Advance the model on current inputs, push, clock, then pop and compare.
    task automatic tick();
        exp_t e;
        if (!clr) begin
            m_q = '0; m_cnt = '0; m_mode = '0; m_busy = 0; m_done = 0;
        end else if (!en) begin
            m_done = 0;
        end else if (m_busy) begin
            m_q   = ref_step(m_mode, m_q);
            m_cnt = m_cnt - 1'b1;
            m_done = (m_cnt == 0);
            m_busy = (m_cnt != 0);
        end else if (start && mode >= 3'd1 && mode <= 3'd5) begin
            m_mode = mode;
            m_done = (shamt == 0);
            m_busy = (shamt != 0);
            m_cnt  = shamt;
        end else begin
            m_done = 0;
            m_q    = ref_step(mode, m_q);
        end
        exp_q.push_back('{q: m_q, busy: m_busy, done: m_done});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("q", 32'(q), 32'(e.q));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        check("sout_r", 32'(sout_r), 32'(e.q[0]));
        check("sout_l", 32'(sout_l), 32'(e.q[W-1]));
    endtask

    task automatic load(input logic [W-1:0] v);
        start = 0; en = 1; mode = 3'b110; pdata = v;
        tick();
        check("load", 32'(q), 32'(v));
    endtask

    initial begin
        clr = 0; en = 1; mode = 0; dr = 0; dl = 0;
        pdata = '0; start = 0; shamt = '0;
        m_q = 'x; m_cnt = 'x; m_mode = 'x; m_busy = 'x; m_done = 'x;
        #1;

        tick();
        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        clr = 1;
        load(8'hA5);
        check("ld_soutl", 32'(sout_l), 1);
        check("ld_soutr", 32'(sout_r), 1);

        mode = 3'b001; dl = 0; tick(); check("shl", 32'(q), 32'h4A);
        mode = 3'b010; dr = 1; tick(); check("shr", 32'(q), 32'hA5);
        mode = 3'b101; tick(); check("asr", 32'(q), 32'hD2);
        load(8'h81); mode = 3'b011; tick(); check("rol", 32'(q), 32'h03);
        load(8'h81); mode = 3'b100; tick(); check("ror", 32'(q), 32'hC0);

        load(8'h81);
        start = 1; mode = 3'b100; shamt = 3; tick();
        check("acc_q", 32'(q), 32'h81);
        check("acc_busy", 32'(busy), 1);
        start = 0; mode = 3'b110; pdata = 8'h55;
        tick(); check("rr1", 32'(q), 32'hC0);
        tick(); check("rr2", 32'(q), 32'h60);
        tick(); check("rr3", 32'(q), 32'h30);
        check("rr_done", 32'(done), 1);
        check("rr_busy", 32'(busy), 0);
        mode = 3'b000; tick(); check("rr_done_clr", 32'(done), 0);

        load(8'h00);
        start = 1; mode = 3'b001; shamt = 2; dl = 1; tick();
        start = 0; mode = 3'b000;
        tick(); check("st1", 32'(q), 32'h01);
        en = 0; tick(); tick();
        check("stall_q", 32'(q), 32'h01);
        check("stall_done", 32'(done), 0);
        en = 1; tick(); check("st2", 32'(q), 32'h03);
        check("st_done", 32'(done), 1);
        tick();

        start = 1; mode = 3'b001; shamt = 0; tick();
        check("z_q", 32'(q), 32'h03);
        check("z_busy", 32'(busy), 0);
        check("z_done", 32'(done), 1);
        start = 0; mode = 3'b000; tick();

        load(8'h80);
        start = 1; mode = 3'b101; shamt = 9; tick();
        start = 0; mode = 3'b000;
        for (int i = 0; i < 9; i++) tick();
        check("asr9", 32'(q), 32'hFF);
        check("asr9_done", 32'(done), 1);
        tick();

        load(8'hA5);
        start = 1; mode = 3'b001; shamt = 10; dl = 0; tick();
        start = 0; mode = 3'b000;
        for (int i = 0; i < 3; i++) tick();
        clr = 0; tick();
        check("abort_q", 32'(q), 32'h00);
        check("abort_busy", 32'(busy), 0);
        clr = 1;
        for (int i = 0; i < 3; i++) tick();
        start = 1; mode = 3'b010; shamt = 2; dr = 1; tick();
        check("restart_busy", 32'(busy), 1);
        start = 0; mode = 3'b000;
        tick(); tick();
        check("restart_q", 32'(q), 32'hC0);
        check("restart_done", 32'(done), 1);

        start = 1; mode = 3'b011; shamt = 2; tick();
        check("b2b_busy", 32'(busy), 1);
        mode = 3'b001; shamt = 5; tick();
        tick();
        check("b2b_q", 32'(q), 32'h03);
        check("b2b_done", 32'(done), 1);
        start = 0; mode = 3'b000; tick();

        for (int i = 0; i < 200; i++) begin
            clr   = ($urandom_range(0, 29) != 0);
            en    = ($urandom_range(0, 4) != 0);
            mode  = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 2) == 0);
            shamt = SW'($urandom_range(0, 11));
            dl    = 1'($urandom_range(0, 1));
            dr    = 1'($urandom_range(0, 1));
            pdata = W'($urandom_range(0, 255));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
